// File: rtl/reaction_game_sequencer.sv
// rtl/reaction_game_sequencer.sv - reaction-time game round controller
// Sequences the random pre-LED delay, the ms reaction counter and the high score.
module reaction_game_sequencer #(
  parameter int DELAY_MIN_MS = 1000,
  parameter int SCORE_MAX    = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Key0,
  input  logic        Key1,
  input  logic        sw0,
  input  logic        ms_tick,
  input  logic [7:0]  lfsr_value,
  output logic [2:0]  state,
  output logic        led,
  output logic [13:0] score,
  output logic [13:0] hiscore,
  output logic        new_record,
  output logic        false_start
);

  localparam logic [11:0] DELAY = 12'(DELAY_MIN_MS);
  localparam logic [13:0] SMAX  = 14'(SCORE_MAX);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ARMED       = 3'd1,
    S_REACT       = 3'd2,
    S_SCORE       = 3'd3,
    S_FALSE_START = 3'd4
  } state_t;

  state_t      cur, nxt;
  logic [2:0]  k0_sync, k1_sync;
  logic        k0_press, k1_press;
  logic [11:0] countdown;
  logic        armed_done, react_timeout;

  // The press pulse is registered, so state moves three edges after the pin is first sampled low.
  always_ff @(posedge clk) begin
    if (reset) begin
      k0_sync  <= 3'b111;
      k1_sync  <= 3'b111;
      k0_press <= 1'b0;
      k1_press <= 1'b0;
    end else begin
      k0_sync  <= {k0_sync[1:0], Key0};
      k1_sync  <= {k1_sync[1:0], Key1};
      k0_press <= k0_sync[2] & ~k0_sync[1];
      k1_press <= k1_sync[2] & ~k1_sync[1];
    end
  end

  assign armed_done    = ms_tick && (countdown == 12'd1);
  assign react_timeout = ms_tick && (score == SMAX - 14'd1);

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE: begin
        if (!k1_press && k0_press) nxt = S_ARMED;
      end
      S_ARMED: begin
        if (k1_press)        nxt = S_IDLE;
        else if (k0_press)   nxt = S_FALSE_START;
        else if (armed_done) nxt = S_REACT;
      end
      S_REACT: begin
        if (k1_press)           nxt = S_IDLE;
        else if (k0_press)      nxt = S_SCORE;
        else if (react_timeout) nxt = S_SCORE;
      end
      S_SCORE, S_FALSE_START: begin
        if (k1_press || k0_press) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur         <= S_IDLE;
      led         <= 1'b0;
      score       <= 14'd0;
      hiscore     <= SMAX;
      new_record  <= 1'b0;
      false_start <= 1'b0;
      countdown   <= 12'd0;
    end else begin
      cur <= nxt;
      led <= (nxt == S_REACT);
      case (cur)
        S_IDLE: begin
          if (k1_press) begin
            if (sw0) hiscore <= SMAX;
          end else if (k0_press) begin
            countdown   <= DELAY + {2'b00, lfsr_value, 2'b00};
            score       <= 14'd0;
            new_record  <= 1'b0;
            false_start <= 1'b0;
          end
        end
        S_ARMED: begin
          if (!k1_press && k0_press) begin
            false_start <= 1'b1;
          end else if (!k1_press && ms_tick) begin
            countdown <= countdown - 12'd1;
            if (countdown == 12'd1) score <= 14'd0;
          end
        end
        // A press wins over a coincident tick; a timeout reaches SMAX which never beats hiscore.
        S_REACT: begin
          if (!k1_press && k0_press) begin
            if (score < hiscore) begin
              hiscore    <= score;
              new_record <= 1'b1;
            end
          end else if (!k1_press && ms_tick && score != SMAX) begin
            score <= score + 14'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_reaction_game_sequencer.sv
// tb/tb_reaction_game_sequencer.sv - vector table and corner sequences with an expected-result queue
module tb_reaction_game_sequencer;

  logic        clk = 1'b0;
  logic        reset, Key0, Key1, sw0, ms_tick;
  logic [7:0]  lfsr_value;
  logic [2:0]  state;
  logic        led, new_record, false_start;
  logic [13:0] score, hiscore;

  always #5 clk = ~clk;

  reaction_game_sequencer dut (
    .clk(clk), .reset(reset), .Key0(Key0), .Key1(Key1), .sw0(sw0),
    .ms_tick(ms_tick), .lfsr_value(lfsr_value), .state(state), .led(led),
    .score(score), .hiscore(hiscore), .new_record(new_record),
    .false_start(false_start)
  );

  typedef enum int {OP_RESET, OP_K0, OP_K1, OP_TICKS} op_t;
  typedef struct {
    op_t op; int arg; int lfsr; bit sw;
    int st; int sc; int hs; bit nr; bit fs; bit led;
  } vec_t;
  typedef struct {
    string name; int st; int sc; int hs; bit nr; bit fs; bit led;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic void add(op_t op, int arg, int lf, bit sw,
                              int st, int sc, int hs, bit nr, bit fs, bit ld);
    vec_t v;
    v.op = op; v.arg = arg; v.lfsr = lf; v.sw = sw;
    v.st = st; v.sc = sc; v.hs = hs; v.nr = nr; v.fs = fs; v.led = ld;
    vecs.push_back(v);
  endfunction

  function automatic void expect_out(string name, int st, int sc, int hs, bit nr, bit fs, bit ld);
    exp_t e;
    e.name = name; e.st = st; e.sc = sc; e.hs = hs; e.nr = nr; e.fs = fs; e.led = ld;
    exp_q.push_back(e);
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
      return;
    end
    e = exp_q.pop_front();
    chk({e.name, ".state"},       int'(state),       e.st);
    chk({e.name, ".score"},       int'(score),       e.sc);
    chk({e.name, ".hiscore"},     int'(hiscore),     e.hs);
    chk({e.name, ".new_record"},  int'(new_record),  int'(e.nr));
    chk({e.name, ".false_start"}, int'(false_start), int'(e.fs));
    chk({e.name, ".led"},         int'(led),         int'(e.led));
  endtask

  task automatic press_keys(input bit k0, input bit k1);
    @(negedge clk);
    Key0 = ~k0; Key1 = ~k1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    Key0 = 1'b1; Key1 = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); ms_tick = 1'b1;
      @(negedge clk); ms_tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; Key0 = 1'b1; Key1 = 1'b1; sw0 = 1'b0; ms_tick = 1'b0; lfsr_value = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    //   op        arg   lfsr sw  st  score  hi    nr fs led
    add(OP_RESET,  0,    0,   0,  0,  0,     9999, 0, 0, 0);
    add(OP_K0,     0,    16,  0,  1,  0,     9999, 0, 0, 0);
    add(OP_TICKS,  1063, 16,  0,  1,  0,     9999, 0, 0, 0);
    add(OP_TICKS,  1,    16,  0,  2,  0,     9999, 0, 0, 1);
    add(OP_TICKS,  250,  0,   0,  2,  250,   9999, 0, 0, 1);
    add(OP_K0,     0,    0,   0,  3,  250,   250,  1, 0, 0);
    add(OP_K0,     0,    0,   0,  0,  250,   250,  1, 0, 0);
    add(OP_K0,     0,    0,   0,  1,  0,     250,  0, 0, 0);
    add(OP_TICKS,  1000, 0,   0,  2,  0,     250,  0, 0, 1);
    add(OP_TICKS,  300,  0,   0,  2,  300,   250,  0, 0, 1);
    add(OP_K0,     0,    0,   0,  3,  300,   250,  0, 0, 0);
    add(OP_K0,     0,    0,   0,  0,  300,   250,  0, 0, 0);
    add(OP_K0,     0,    0,   0,  1,  0,     250,  0, 0, 0);
    add(OP_TICKS,  1000, 0,   0,  2,  0,     250,  0, 0, 1);
    add(OP_TICKS,  250,  0,   0,  2,  250,   250,  0, 0, 1);
    add(OP_K0,     0,    0,   0,  3,  250,   250,  0, 0, 0);
    add(OP_K0,     0,    0,   0,  0,  250,   250,  0, 0, 0);
    add(OP_K0,     0,    0,   0,  1,  0,     250,  0, 0, 0);
    add(OP_TICKS,  5,    0,   0,  1,  0,     250,  0, 0, 0);
    add(OP_K0,     0,    0,   0,  4,  0,     250,  0, 1, 0);
    add(OP_TICKS,  200,  0,   0,  4,  0,     250,  0, 1, 0);
    add(OP_K0,     0,    0,   0,  0,  0,     250,  0, 1, 0);
    add(OP_K0,     0,    0,   0,  1,  0,     250,  0, 0, 0);
    add(OP_TICKS,  1000, 0,   0,  2,  0,     250,  0, 0, 1);
    add(OP_TICKS,  9999, 0,   0,  3,  9999,  250,  0, 0, 0);
    add(OP_TICKS,  10,   0,   0,  3,  9999,  250,  0, 0, 0);
    add(OP_K0,     0,    0,   0,  0,  9999,  250,  0, 0, 0);
    add(OP_K0,     0,    0,   0,  1,  0,     250,  0, 0, 0);
    add(OP_TICKS,  1000, 0,   0,  2,  0,     250,  0, 0, 1);
    add(OP_TICKS,  40,   0,   0,  2,  40,    250,  0, 0, 1);
    add(OP_K1,     0,    0,   0,  0,  40,    250,  0, 0, 0);
    add(OP_K1,     0,    0,   0,  0,  40,    250,  0, 0, 0);
    add(OP_K1,     0,    0,   1,  0,  40,    9999, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      lfsr_value = 8'(vecs[i].lfsr);
      sw0 = vecs[i].sw;
      expect_out($sformatf("v%0d", i), vecs[i].st, vecs[i].sc, vecs[i].hs,
                 vecs[i].nr, vecs[i].fs, vecs[i].led);
      case (vecs[i].op)
        OP_RESET: do_reset();
        OP_K0:    press_keys(1'b1, 1'b0);
        OP_K1:    press_keys(1'b0, 1'b1);
        default:  do_ticks(vecs[i].arg);
      endcase
      @(negedge clk);
      compare_out();
    end
    sw0 = 1'b0;
    lfsr_value = 8'h00;

    // Key0 press coincident with a tick in REACT: tick dropped, and the press latency is exact.
    press_keys(1'b1, 1'b0);
    do_ticks(1000);
    do_ticks(7);
    @(negedge clk); Key0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("latency_n2.state", int'(state), 2);
    ms_tick = 1'b1;
    @(posedge clk);
    #1;
    ms_tick = 1'b0;
    chk("latency_n3.state", int'(state), 3);
    expect_out("coincident_tick", 3, 7, 7, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    compare_out();
    Key0 = 1'b1;
    repeat (4) @(posedge clk);
    expect_out("score_to_idle", 0, 7, 7, 1'b1, 1'b0, 1'b0);
    press_keys(1'b1, 1'b0);
    @(negedge clk); compare_out();

    // Both keys in the same cycle while ARMED: abort wins.
    press_keys(1'b1, 1'b0);
    do_ticks(3);
    expect_out("both_keys_armed", 0, 0, 7, 1'b0, 1'b0, 1'b0);
    press_keys(1'b1, 1'b1);
    @(negedge clk); compare_out();

    // Reset while ARMED, then a fresh round with lfsr=1 lasts exactly 1004 ticks.
    press_keys(1'b1, 1'b0);
    do_ticks(3);
    expect_out("reset_in_armed", 0, 0, 9999, 1'b0, 1'b0, 1'b0);
    do_reset();
    @(negedge clk); compare_out();
    lfsr_value = 8'h01;
    press_keys(1'b1, 1'b0);
    lfsr_value = 8'h00;
    expect_out("post_reset_1003", 1, 0, 9999, 1'b0, 1'b0, 1'b0);
    do_ticks(1003);
    @(negedge clk); compare_out();
    expect_out("post_reset_1004", 2, 0, 9999, 1'b0, 1'b0, 1'b1);
    do_ticks(1);
    @(negedge clk); compare_out();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
